// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings and the read-DMA FSM state type.
package ahbl_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_WORD    = 3'b010;
   localparam logic [2:0] HBURST_INCR   = 3'b001;

   localparam logic       HRESP_OKAY    = 1'b0;
   localparam logic       HRESP_ERROR   = 1'b1;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StErr
   } rd_dma_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; DEPTH must be a power of two.
module sync_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int unsigned AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign full    = (count_q == FULL_CNT);
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   // Head reads as zero when empty so stale words never leak after reset.
   assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/ahbl_rom_rd_dma.sv
// AHB-Lite word-read master: pipelined INCR reads from src_addr into a FIFO exposed as a
// valid/ready stream. FIFO space is reserved at address issue so data phases never stall.
module ahbl_rom_rd_dma
   import ahbl_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             HCLK,
   input  logic             HRESET,
   input  logic             start,
   input  logic [31:0]      src_addr,
   input  logic [CNT_W-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [31:0]      HADDR,
   output logic [1:0]       HTRANS,
   output logic [2:0]       HSIZE,
   output logic [2:0]       HBURST,
   output logic             HWRITE,
   input  logic             HREADY,
   input  logic             HRESP,
   input  logic [31:0]      HRDATA,
   output logic [31:0]      m_tdata,
   output logic             m_tvalid,
   input  logic             m_tready
);
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   rd_dma_state_e    state_q, state_d;
   logic [31:0]      addr_q, addr_d;
   logic [CNT_W-1:0] left_q, left_d;
   logic [31:0]      haddr_q, haddr_d;
   logic [1:0]       htrans_q, htrans_d;
   logic             inflight_q, inflight_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic             push, pop, fifo_full, fifo_empty, space_ok;
   logic [CW-1:0]    fifo_count;
   logic [CW:0]      fifo_next;

   assign push      = inflight_q & HREADY & (HRESP == HRESP_OKAY) & ~fifo_full;
   assign pop       = ~fifo_empty & m_tready;
   assign fifo_next = {1'b0, fifo_count} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};

   sync_fifo #(
      .WIDTH (32),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (HCLK),
      .rst   (HRESET),
      .push  (push),
      .pop   (pop),
      .wdata (HRDATA),
      .rdata (m_tdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      left_d     = left_q;
      haddr_d    = haddr_q;
      htrans_d   = htrans_q;
      inflight_d = inflight_q;
      done_d     = 1'b0;
      err_d      = err_q;
      space_ok   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               err_d = 1'b0;
               if (count == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = StRun;
                  addr_d  = src_addr & 32'hFFFF_FFFC;
                  left_d  = count;
               end
            end
         end
         StRun: begin
            if (inflight_q && (HRESP == HRESP_ERROR)) begin
               // First error cycle: withdraw the pipelined address phase.
               htrans_d = HTRANS_IDLE;
               if (HREADY) begin
                  state_d    = StIdle;
                  err_d      = 1'b1;
                  done_d     = 1'b1;
                  inflight_d = 1'b0;
               end else begin
                  state_d = StErr;
               end
            end else if (push && (left_q == '0) && (htrans_q == HTRANS_IDLE)) begin
               state_d    = StIdle;
               done_d     = 1'b1;
               inflight_d = 1'b0;
            end
         end
         StErr: begin
            htrans_d = HTRANS_IDLE;
            if (HREADY) begin
               state_d    = StIdle;
               err_d      = 1'b1;
               done_d     = 1'b1;
               inflight_d = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase

      // Bus outputs advance only on edges where the slave is ready.
      if (HREADY && (state_d == StRun)) begin
         inflight_d = (htrans_q != HTRANS_IDLE);
         space_ok   = (fifo_next + {{CW{1'b0}}, inflight_d} + (CW+1)'(1))
                      <= (CW+1)'(FIFO_DEPTH);
         if ((left_d != '0) && space_ok) begin
            htrans_d = ((htrans_q == HTRANS_IDLE) || (addr_d[9:0] == 10'd0)) ?
                       HTRANS_NONSEQ : HTRANS_SEQ;
            haddr_d  = addr_d;
            addr_d   = addr_d + 32'd4;
            left_d   = left_d - CNT_W'(1);
         end else begin
            htrans_d = HTRANS_IDLE;
         end
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         left_q     <= '0;
         haddr_q    <= '0;
         htrans_q   <= HTRANS_IDLE;
         inflight_q <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         left_q     <= left_d;
         haddr_q    <= haddr_d;
         htrans_q   <= htrans_d;
         inflight_q <= inflight_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign busy     = (state_q != StIdle);
   assign done     = done_q;
   assign err      = err_q;
   assign HADDR    = haddr_q;
   assign HTRANS   = htrans_q;
   assign HSIZE    = HSIZE_WORD;
   assign HBURST   = HBURST_INCR;
   assign HWRITE   = 1'b0;
   assign m_tvalid = ~fifo_empty;

endmodule

// File: tb/tb_ahbl_rom_rd_dma.sv
// Bench for ahbl_rom_rd_dma with a behavioural ROM slave (ROM[i] = A500_0000 + i),
// optional error word, random wait states and random stream back-pressure.
module tb_ahbl_rom_rd_dma;
   import ahbl_pkg::*;

   logic        HCLK = 1'b0;
   logic        HRESET = 1'b1;
   logic        start = 1'b0;
   logic [31:0] src_addr = '0;
   logic [15:0] count = '0;
   logic        busy, done, err;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE, HBURST;
   logic        HWRITE, HREADY, HRESP;
   logic [31:0] HRDATA, m_tdata;
   logic        m_tvalid;
   logic        m_tready = 1'b1;

   ahbl_rom_rd_dma #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .start(start), .src_addr(src_addr), .count(count),
      .busy(busy), .done(done), .err(err), .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE),
      .HBURST(HBURST), .HWRITE(HWRITE), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready)
   );

   always #5 HCLK = ~HCLK;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   always @(posedge HCLK) cyc <= cyc + 1;

   // slave / environment knobs
   logic        err_en = 1'b0;
   logic [31:0] err_addr = '0;
   logic        stall_en = 1'b0;
   logic        rdy_rand = 1'b0;

   logic        dp_valid, dp_err, err_second;
   logic [31:0] dp_addr;
   int unsigned wait_cnt;

   always @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         dp_valid <= 1'b0; dp_err <= 1'b0; err_second <= 1'b0; dp_addr <= '0; wait_cnt <= 0;
      end else if (HREADY) begin
         dp_valid   <= HTRANS[1];
         dp_addr    <= HADDR;
         dp_err     <= err_en && HTRANS[1] && (HADDR == err_addr);
         wait_cnt   <= (stall_en && HTRANS[1]) ? $urandom_range(0, 2) : 0;
         err_second <= 1'b0;
      end else if (dp_err) begin
         err_second <= 1'b1;
      end else if (wait_cnt != 0) begin
         wait_cnt <= wait_cnt - 1;
      end
   end

   assign HREADY = !dp_valid || (dp_err ? err_second : (wait_cnt == 0));
   assign HRESP  = dp_valid && dp_err;
   assign HRDATA = dp_valid ? (32'hA500_0000 + (dp_addr >> 2)) : 32'h0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // reference model state
   logic [31:0] exp_q[$];
   logic [31:0] bus_next;
   int beats, accepted, nonseq, done_cnt, first_cyc, first_hs, last_hs, t0;
   logic busy_seen;
   logic [31:0] first_w, last_w;

   logic        prev_valid = 1'b0;
   logic        prev_ready, prev_resp;
   logic [1:0]  prev_trans;
   logic [31:0] prev_addr;
   logic [1:0]  last_trans = HTRANS_IDLE;

   // Samples mid-cycle: values here are what the next rising edge will see.
   always @(negedge HCLK) begin
      if (HRESET) begin
         prev_valid = 1'b0;
         last_trans = HTRANS_IDLE;
      end else begin
         if (busy) busy_seen = 1'b1;
         if (done) done_cnt++;
         if (m_tvalid && first_cyc < 0) first_cyc = cyc;
         if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) check("extra_beat", m_tdata, 32'hFFFF_FFFF);
            else begin
               logic [31:0] e;
               e = exp_q.pop_front();
               check("stream_data", m_tdata, e);
            end
            if (beats == 0) begin first_hs = cyc; first_w = m_tdata; end
            last_hs = cyc;
            last_w  = m_tdata;
            beats++;
         end
         if (HREADY) begin
            if (HTRANS[1]) begin
               check("haddr", HADDR, bus_next);
               check("htrans_kind", {30'd0, HTRANS},
                     {30'd0, ((last_trans == HTRANS_IDLE) || (HADDR[9:0] == 10'd0)) ?
                      HTRANS_NONSEQ : HTRANS_SEQ});
               if (HTRANS == HTRANS_NONSEQ) nonseq++;
               bus_next = bus_next + 32'd4;
               accepted++;
            end
            last_trans = HTRANS;
         end
         if (prev_valid && !prev_ready && !prev_resp) begin
            check("hold_haddr", HADDR, prev_addr);
            check("hold_htrans", {30'd0, HTRANS}, {30'd0, prev_trans});
         end
         prev_valid = 1'b1;
         prev_ready = HREADY;
         prev_resp  = HRESP;
         prev_trans = HTRANS;
         prev_addr  = HADDR;
      end
   end

   task automatic tick();
      @(posedge HCLK);
      #1;
      if (rdy_rand) m_tready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic do_start(input logic [31:0] src, input logic [15:0] cnt);
      logic [31:0] base;
      int unsigned n;
      base = src & 32'hFFFF_FFFC;
      n    = cnt;
      if (err_en && err_addr >= base && err_addr < base + 32'd4 * cnt)
         n = (err_addr - base) / 4;
      for (int unsigned i = 0; i < n; i++) exp_q.push_back(32'hA500_0000 + (base >> 2) + i);
      bus_next = base;
      beats = 0; accepted = 0; nonseq = 0; done_cnt = 0; first_cyc = -1;
      busy_seen = 1'b0;
      t0 = cyc;
      src_addr = src;
      count    = cnt;
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget && done_cnt == 0; i++) tick();
      check("done_seen", {31'd0, done_cnt > 0}, 32'd1);
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
      check("drained", exp_q.size(), 32'd0);
   endtask

   typedef struct {
      logic [31:0] src;
      logic [15:0] cnt;
      logic [31:0] first_w;
      logic [31:0] last_w;
      int          nonseq;
   } vec_t;
   vec_t vecs [5];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] src6;

      vecs[0] = '{32'h0000_0000, 16'd8, 32'hA500_0000, 32'hA500_0007, 1};
      vecs[1] = '{32'h0000_03F8, 16'd4, 32'hA500_00FE, 32'hA500_0101, 2};
      vecs[2] = '{32'h0000_0100, 16'd1, 32'hA500_0040, 32'hA500_0040, 1};
      vecs[3] = '{32'h0000_07F0, 16'd5, 32'hA500_01FC, 32'hA500_0200, 2};
      vecs[4] = '{32'h0000_0203, 16'd3, 32'hA500_0080, 32'hA500_0082, 1};

      repeat (3) tick();
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_htrans", {30'd0, HTRANS}, 32'd0);
      HRESET = 1'b0;
      tick();
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_haddr", HADDR, 32'd0);
      check("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
      check("hsize", {29'd0, HSIZE}, 32'd2);
      check("hburst", {29'd0, HBURST}, 32'd1);
      check("hwrite", {31'd0, HWRITE}, 32'd0);

      // zero-wait, always-ready transfers
      for (int v = 0; v < 5; v++) begin
         do_start(vecs[v].src, vecs[v].cnt);
         wait_done(200);
         wait_drain(50);
         repeat (2) tick();
         check("done_pulses", done_cnt, 32'd1);
         check("beats", beats, {16'd0, vecs[v].cnt});
         check("first_word", first_w, vecs[v].first_w);
         check("last_word", last_w, vecs[v].last_w);
         check("nonseq_count", nonseq, vecs[v].nonseq);
         check("first_valid_latency", first_cyc - t0, 32'd3);
         check("back_to_back", last_hs - first_hs, {16'd0, vecs[v].cnt} - 32'd1);
         check("end_busy", {31'd0, busy}, 32'd0);
         check("end_htrans_idle", {30'd0, HTRANS}, 32'd0);
      end

      // back-pressure: only FIFO_DEPTH reads in flight, then NONSEQ restart
      m_tready = 1'b0;
      do_start(32'h10, 16'd6);
      repeat (12) tick();
      check("bp_accepted", accepted, 32'd4);
      check("bp_htrans_idle", {30'd0, HTRANS}, 32'd0);
      check("bp_tvalid", {31'd0, m_tvalid}, 32'd1);
      src_addr = 32'h5000; count = 16'd3; start = 1'b1;
      tick();
      start = 1'b0;
      check("busy_start_ignored", {31'd0, busy}, 32'd1);
      repeat (3) tick();
      check("bp_still_4", accepted, 32'd4);
      m_tready = 1'b1;
      wait_done(100);
      wait_drain(50);
      check("bp_accepted_all", accepted, 32'd6);
      check("bp_nonseq", nonseq, 32'd2);
      check("bp_beats", beats, 32'd6);

      // count == 0
      do_start(32'h40, 16'd0);
      check("zero_done_c1", {31'd0, done}, 32'd1);
      check("zero_busy", {31'd0, busy}, 32'd0);
      tick();
      check("zero_done_pulse", {31'd0, done}, 32'd0);
      repeat (3) tick();
      check("zero_busy_never", {31'd0, busy_seen}, 32'd0);
      check("zero_no_bus", accepted, 32'd0);

      // error response at 0x8
      err_en = 1'b1; err_addr = 32'h8;
      do_start(32'h0, 16'd4);
      wait_done(100);
      wait_drain(50);
      repeat (3) tick();
      check("err_flag", {31'd0, err}, 32'd1);
      check("err_done_pulses", done_cnt, 32'd1);
      check("err_beats", beats, 32'd2);
      check("err_accepted", accepted, 32'd3);
      check("err_busy", {31'd0, busy}, 32'd0);
      err_en = 1'b0;
      do_start(32'h20, 16'd2);
      check("err_cleared", {31'd0, err}, 32'd0);
      wait_done(100);
      wait_drain(50);
      check("after_err_beats", beats, 32'd2);

      // random stalls and back-pressure
      stall_en = 1'b1; rdy_rand = 1'b1;
      src6 = $urandom_range(0, 1023) << 2;
      do_start(src6, 16'd100);
      wait_done(3000);
      wait_drain(200);
      check("rand_beats", beats, 32'd100);
      check("rand_done_pulses", done_cnt, 32'd1);

      src6 = $urandom_range(0, 1023) << 2;
      do_start(src6, 16'd100);
      for (int i = 0; i < 3000 && beats < 50; i++) tick();
      check("rand_reached_50", {31'd0, beats >= 50}, 32'd1);
      @(posedge HCLK);
      #2;
      HRESET = 1'b1;
      #1;
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_done", {31'd0, done}, 32'd0);
      check("mid_rst_err", {31'd0, err}, 32'd0);
      check("mid_rst_htrans", {30'd0, HTRANS}, 32'd0);
      check("mid_rst_haddr", HADDR, 32'd0);
      check("mid_rst_tvalid", {31'd0, m_tvalid}, 32'd0);
      exp_q.delete();
      stall_en = 1'b0; rdy_rand = 1'b0; m_tready = 1'b1;
      repeat (2) tick();
      HRESET = 1'b0;
      repeat (2) tick();
      check("post_rst_tvalid", {31'd0, m_tvalid}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
